// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush scheduler for a 5-stage RISC-V pipeline (load-use bubble, branch flush, multi-cycle op hold).
// Latency: control outputs are combinational from state and inputs; state, wait counter, mc_err and perf counters are registered.
// Backpressure: holds F/D/E while a multi-cycle op is outstanding, released by mc_done or a bounded timeout.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset (0 = reset, all controls forced low)
//   Rs1_D, Rs2_D             source registers of the Decode instruction
//   RD_E, MemReadE           destination / is-load of the Execute instruction
//   PCSrcE, MulOpE           taken branch/jump, multi-cycle op in Execute
//   mc_done / mc_start       multi-cycle unit handshake
//   StallF/D/E, FlushD/E/M   pipeline register hold / clear controls
//   mc_err                   sticky multi-cycle timeout flag
//   stall_cnt, flush_cnt     saturating perf counters
// Optional feature macro: PERF_CNT_EN builds the perf counters; otherwise both read 0.
module pipeline_stall_ctrl #(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32,
  parameter int REG_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] Rs1_D,
  input  logic [REG_W-1:0] Rs2_D,
  input  logic [REG_W-1:0] RD_E,
  input  logic             MemReadE,
  input  logic             PCSrcE,
  input  logic             MulOpE,
  input  logic             mc_done,
  output logic             mc_start,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             mc_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WC_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MC_TIMEOUT - 1);

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            mc_err_q, mc_err_d;
  logic            lu;

  // Load-use: the load's result is not available for forwarding into Decode yet.
  assign lu = MemReadE & (RD_E != '0) & ((RD_E == Rs1_D) | (RD_E == Rs2_D));

  always_comb begin
    mc_start   = 1'b0;
    StallF     = 1'b0;
    StallD     = 1'b0;
    StallE     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    FlushM     = 1'b0;
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mc_err_d   = mc_err_q;

    case (state_q)
      RUN: begin
        if (PCSrcE) begin
          // Wrong-path instructions in D and E are squashed; a load-use
          // stall on a squashed instruction would be pointless.
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (MulOpE) begin
          mc_start   = 1'b1;
          StallF     = 1'b1;
          StallD     = 1'b1;
          StallE     = 1'b1;
          FlushM     = 1'b1;
          wait_cnt_d = '0;
          state_d    = MC_WAIT;
        end else if (lu) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
      end
      MC_WAIT: begin
        if (mc_done) begin
          state_d = RUN;
        end else if (wait_cnt_q == WC_LAST) begin
          // Give up on the unit; pipeline resumes with mc_err recorded.
          mc_err_d = 1'b1;
          state_d  = RUN;
        end else begin
          StallF     = 1'b1;
          StallD     = 1'b1;
          StallE     = 1'b1;
          FlushM     = 1'b1;
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end
      default: state_d = RUN;
    endcase

    // Controls stay quiet for the whole reset window, whatever the inputs do.
    if (!rst) begin
      mc_start = 1'b0;
      StallF   = 1'b0;
      StallD   = 1'b0;
      StallE   = 1'b0;
      FlushD   = 1'b0;
      FlushE   = 1'b0;
      FlushM   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mc_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mc_err_q   <= mc_err_d;
    end
  end

  assign mc_err = mc_err_q;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // FlushD is only ever raised by a branch flush in RUN, so it doubles as the flush event.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallF && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (FlushD && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
